// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioning path: channel FSM encoding
// and the bit position of each board button in the N_BTN-wide vectors.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DB_PRESS = 3'd1,
        ST_HELD_DLY = 3'd2,
        ST_HELD_RPT = 3'd3,
        ST_DB_REL   = 3'd4
    } btn_state_e;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, debounce FSM with tick-enabled counter,
// and registered level / press / release / move outputs.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_TICKS   = 16,
    parameter int RPT_DELAY  = 24,
    parameter int RPT_PERIOD = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_move
);

    logic [1:0]       sync_q;
    logic             btn_sync;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             from_rpt;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign btn_sync = sync_q[1];
    assign cnt_inc  = cnt + 1'b1;

    // Debounce compares the incremented value so acceptance lands on the
    // DB_TICKS-th tick; repeat timers compare the stored count instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            from_rpt    <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_move    <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_move    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_sync) begin
                        state <= ST_DB_PRESS;
                        cnt   <= '0;
                    end
                end
                ST_DB_PRESS: begin
                    if (!btn_sync) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt_inc == CNT_W'(DB_TICKS)) begin
                            state     <= ST_HELD_DLY;
                            cnt       <= '0;
                            btn_level <= 1'b1;
                            btn_press <= 1'b1;
                            btn_move  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_HELD_DLY: begin
                    if (!btn_sync) begin
                        state    <= ST_DB_REL;
                        cnt      <= '0;
                        from_rpt <= 1'b0;
                    end else if (cnt == CNT_W'(RPT_DELAY)) begin
                        state    <= ST_HELD_RPT;
                        cnt      <= '0;
                        btn_move <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                    end
                end
                ST_HELD_RPT: begin
                    if (!btn_sync) begin
                        state    <= ST_DB_REL;
                        cnt      <= '0;
                        from_rpt <= 1'b1;
                    end else if (cnt == CNT_W'(RPT_PERIOD)) begin
                        cnt      <= '0;
                        btn_move <= 1'b1;
                    end else if (tick) begin
                        cnt <= cnt_inc;
                    end
                end
                ST_DB_REL: begin
                    if (btn_sync) begin
                        state <= from_rpt ? ST_HELD_RPT : ST_HELD_DLY;
                        cnt   <= '0;
                    end else if (tick) begin
                        if (cnt_inc == CNT_W'(DB_TICKS)) begin
                            state       <= ST_IDLE;
                            cnt         <= '0;
                            btn_level   <= 1'b0;
                            btn_release <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the raw board buttons into clean levels and single-cycle
// press / release / move strobes, one independent channel per button.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 5,
    parameter int DB_TICKS   = 16,
    parameter int RPT_DELAY  = 24,
    parameter int RPT_PERIOD = 8,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_move
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DB_TICKS  (DB_TICKS),
            .RPT_DELAY (RPT_DELAY),
            .RPT_PERIOD(RPT_PERIOD),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .tick       (tick),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_move   (btn_move[i])
        );
    end

endmodule
